// File: rtl/conv2_ch_sched.sv
// Time-multiplexed XNOR-popcount scheduler for conv2: one 72-bit window per handshake,
// LANES channels per cycle from an external combinational weight ROM, 16-bit packed result.
module conv2_ch_sched #(
  parameter  int unsigned WINDOW_SIZE = 72,
  parameter  int unsigned NUM_OUT_CH  = 16,
  parameter  int unsigned LANES       = 4,
  parameter  int unsigned THRESH      = 36,
  localparam int unsigned G           = NUM_OUT_CH / LANES,
  localparam int unsigned GW          = (G > 1) ? $clog2(G) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in_buf,
  output logic                         ready_out,
  input  logic [WINDOW_SIZE-1:0]       pixel_windows,
  output logic [GW-1:0]                w_grp,
  input  logic [LANES*WINDOW_SIZE-1:0] w_data,
  output logic [NUM_OUT_CH-1:0]        conv2_out,
  output logic                         valid_out_conv2,
  input  logic                         out_ready
);

  localparam int unsigned PW = $clog2(WINDOW_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_OUT
  } state_e;

  state_e                  state_q, state_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [WINDOW_SIZE-1:0]  win_q, win_d;
  logic [NUM_OUT_CH-1:0]   res_q, res_d;
  logic [NUM_OUT_CH-1:0]   out_q, out_d;
  logic                    vld_q, vld_d;
  logic [LANES-1:0]        lane_hit;

  // Per-lane XNOR popcount against the group's weights, thresholded
  always_comb begin
    logic [WINDOW_SIZE-1:0] match;
    logic [PW-1:0]          cnt;
    lane_hit = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      match = ~(win_q ^ w_data[l*WINDOW_SIZE +: WINDOW_SIZE]);
      cnt   = '0;
      for (int unsigned b = 0; b < WINDOW_SIZE; b++) begin
        cnt = cnt + PW'(match[b]);
      end
      lane_hit[l] = (cnt >= PW'(THRESH));
    end
  end

  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    win_d     = win_q;
    res_d     = res_q;
    out_d     = out_q;
    vld_d     = vld_q;
    ready_out = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_out = 1'b1;
        if (valid_in_buf) begin
          win_d   = pixel_windows;
          grp_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        for (int unsigned g = 0; g < G; g++) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            if (grp_q == GW'(g)) begin
              res_d[g*LANES + l] = lane_hit[l];
            end
          end
        end
        grp_d = grp_q + GW'(1);
        // The final group's bits go straight to the output register with the rest
        if (grp_q == GW'(G - 1)) begin
          out_d   = res_d;
          vld_d   = 1'b1;
          grp_d   = '0;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        ready_out = out_ready;
        if (out_ready) begin
          out_d = '0;
          vld_d = 1'b0;
          if (valid_in_buf) begin
            win_d   = pixel_windows;
            grp_d   = '0;
            state_d = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        grp_d   = '0;
        out_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      win_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      win_q   <= win_d;
      res_q   <= res_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign w_grp           = (state_q == S_CALC) ? grp_q : '0;
  assign conv2_out       = out_q;
  assign valid_out_conv2 = vld_q;

endmodule

// File: tb/tb_conv2_ch_sched.sv
// Scoreboard bench for conv2_ch_sched: driver predicts results from a behavioural ROM/popcount
// model and queues them; an independent monitor pops and compares each presented output.
module tb_conv2_ch_sched;

  localparam int W  = 72;
  localparam int N  = 16;
  localparam int L  = 4;
  localparam int G  = N / L;
  localparam int TH = 36;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           valid_in_buf;
  logic           ready_out;
  logic [W-1:0]   pixel_windows;
  logic [1:0]     w_grp;
  logic [L*W-1:0] w_data;
  logic [N-1:0]   conv2_out;
  logic           valid_out_conv2;
  logic           out_ready;

  logic [W-1:0]   rom [N];

  typedef struct {
    logic [N-1:0] d;
    int           acc;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m_calc = 0;
  bit m_out  = 0;

  conv2_ch_sched #(
    .WINDOW_SIZE(W),
    .NUM_OUT_CH (N),
    .LANES      (L),
    .THRESH     (TH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in_buf   (valid_in_buf),
    .ready_out      (ready_out),
    .pixel_windows  (pixel_windows),
    .w_grp          (w_grp),
    .w_data         (w_data),
    .conv2_out      (conv2_out),
    .valid_out_conv2(valid_out_conv2),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    w_data = '0;
    for (int l = 0; l < L; l++) w_data[l*W +: W] = rom[int'(w_grp)*L + l];
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel c fires when at least TH window bits equal its weight bits
  function automatic logic [N-1:0] ref_out(input logic [W-1:0] win);
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = ($countones(~(win ^ rom[c])) >= TH);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_win();
    logic [W-1:0] r;
    r[31:0]  = $urandom();
    r[63:32] = $urandom();
    r[71:64] = 8'($urandom());
    return r;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] win, input logic ordy, output bit acc);
    bit   exp_rdy;
    exp_t e;
    @(negedge clk);
    valid_in_buf  = v;
    pixel_windows = win;
    out_ready     = ordy;
    #1;
    exp_rdy = (m_calc == 0) && (!m_out || ordy);
    chk("ready_out", W'(ready_out), W'(exp_rdy));
    chk("w_grp", W'(w_grp), (m_calc > 0) ? W'(G - m_calc) : '0);
    acc = v && exp_rdy;
    if (acc) begin
      e.d   = ref_out(win);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    if (m_out && ordy) m_out = 0;
    if (m_calc > 0) begin
      m_calc--;
      if (m_calc == 0) m_out = 1;
    end
    if (acc) m_calc = G;
  endtask

  task automatic send(input logic [W-1:0] win, input logic ordy);
    bit acc = 0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b1, win, ordy, acc);
    if (!acc) chk("accept_timeout", W'(0), W'(1));
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 40 && (m_calc != 0 || m_out); i++) step(1'b0, rnd_win(), 1'b1, a);
    if (m_calc != 0 || m_out) chk("drain_timeout", W'(0), W'(1));
    step(1'b0, rnd_win(), 1'b1, a);
  endtask

  // Monitor: pops one expectation per new output and checks hold/clear behaviour
  initial begin
    bit           holding = 0;
    logic [N-1:0] held = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        holding = 0;
        continue;
      end
      if (valid_out_conv2) begin
        if (!holding) begin
          if (q.size() == 0) begin
            chk("unexpected_output", W'(1), W'(0));
          end else begin
            e = q.pop_front();
            chk("conv2_out", W'(conv2_out), W'(e.d));
            chk("latency", W'(cyc), W'(e.acc + G));
          end
          held    = conv2_out;
          holding = 1;
        end else begin
          chk("hold_data", W'(conv2_out), W'(held));
        end
        if (out_ready) holding = 0;
      end else begin
        chk("out_zero_when_invalid", W'(conv2_out), '0);
        chk("valid_dropped_unconsumed", W'(holding), '0);
        holding = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           a;
    logic [W-1:0] wa, wb;
    for (int c = 0; c < N; c++) rom[c] = '0;
    rst_n = 1'b1;
    valid_in_buf = 1'b0;
    out_ready = 1'b0;
    pixel_windows = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", W'(ready_out), W'(1));
    chk("rst_valid", W'(valid_out_conv2), W'(0));
    chk("rst_out", W'(conv2_out), '0);
    chk("rst_wgrp", W'(w_grp), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send('0, 1'b1);
    drain();
    send('1, 1'b1);
    drain();
    send(72'hFF_FFFF_FFF0_0000_0000, 1'b1);
    drain();
    send(72'hFF_FFFF_FFF8_0000_0000, 1'b1);
    drain();

    for (int c = 0; c < N; c++) rom[c] = (c % 2 == 1) ? '1 : '0;
    send('0, 1'b1);
    drain();

    for (int c = 0; c < N; c++) rom[c] = rnd_win();
    wa = rnd_win();
    wb = rnd_win();
    send(wa, 1'b0);
    for (int i = 0; i < 20 && !m_out; i++) step(1'b1, wb, 1'b0, a);
    for (int i = 0; i < 5; i++) step(1'b1, wb, 1'b0, a);
    send(wb, 1'b1);
    drain();

    for (int k = 0; k < 3; k++) send(rnd_win(), 1'b1);
    drain();

    send(rnd_win(), 1'b1);
    step(1'b0, rnd_win(), 1'b1, a);
    step(1'b0, rnd_win(), 1'b1, a);
    @(negedge clk);
    #3;
    chk("pre_reset_wgrp", W'(w_grp), W'(2));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'(valid_out_conv2), W'(0));
    chk("midrst_out", W'(conv2_out), '0);
    chk("midrst_ready", W'(ready_out), W'(1));
    q.delete();
    m_calc = 0;
    m_out  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(rnd_win(), 1'b1);
    drain();

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), rnd_win(), ($urandom_range(0, 9) < 7), a);
    drain();
    chk("queue_empty", W'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv2_ch_sched.md
# conv2_ch_sched

Time-multiplexed scheduler for the conv2 binary convolution stage. It accepts one 3x3x8 binarized window (72 bits) per handshake and shares LANES XNOR-popcount lanes across NUM_OUT_CH output channels, one channel group per cycle. Weights for each group are fetched from an external combinational weight ROM. The block packs the thresholded bits into a 16-bit output word and presents it to the pooling stage with a valid/ready handshake.

## Interface
- WINDOW_SIZE, 72: bits per window (3x3 kernel x 8 input channels)
- NUM_OUT_CH, 16: output channels
- LANES, 4: channels evaluated per cycle; must divide NUM_OUT_CH
- THRESH, 36: popcount threshold; output bit = 1 when popcount >= THRESH
- Derived: G = NUM_OUT_CH/LANES (4); GW = max(1, clog2(G)) (2)

Ports:
- clk  in  1  clock; everything updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in_buf  in  1  window valid from the line buffer
- ready_out  out  1  scheduler can accept a window this cycle
- pixel_windows  in  WINDOW_SIZE  binarized window
- w_grp  out  GW  weight ROM group address
- w_data  in  LANES*WINDOW_SIZE  combinational ROM data for w_grp
  - lane l occupies bits [l*WINDOW_SIZE +: WINDOW_SIZE] and is channel w_grp*LANES+l
- conv2_out  out  NUM_OUT_CH  bit c = result of output channel c
- valid_out_conv2  out  1  conv2_out valid
- out_ready  in  1  downstream accepts conv2_out

## Operation
- FSM has three states: IDLE, CALC, OUT.
- IDLE
  - ready_out = 1.
  - On valid_in_buf: capture pixel_windows into win_reg, set grp = 0, go to CALC.
- CALC
  - ready_out = 0; w_grp = grp.
  - Each lane computes popcount(~(win_reg ^ lane weight)), 7 bits unsigned, and compares it with `>= THRESH`.
  - Each lane result is written to res_reg[grp*LANES + l].
  - grp increments each cycle. When grp = G-1: conv2_out <= final res_reg (including this group), valid_out_conv2 <= 1, go to OUT.
- OUT
  - conv2_out and valid_out_conv2 hold stable.
  - ready_out = out_ready.
  - If out_ready and valid_in_buf: output completes, the new window is captured, grp = 0, go to CALC, and valid_out_conv2 drops next cycle.
  - If out_ready and !valid_in_buf: go to IDLE.
  - If !out_ready: stay in OUT.
- conv2_out is 0 whenever valid_out_conv2 is 0; it is cleared when leaving OUT.
- pixel_windows and valid_in_buf are ignored while ready_out = 0. Changes to pixel_windows during CALC have no effect.
- w_grp is 0 outside CALC. Its value is don't-care to the ROM outside CALC.
- res_reg is overwritten group by group and is never read partially.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, grp = 0, w_grp = 0
  - conv2_out = 0, valid_out_conv2 = 0
  - res_reg = 0, win_reg = 0
  - ready_out = 1 once state is IDLE
- Reset mid-CALC or mid-OUT discards the window in flight. No output is produced for it.
- Latency: a window accepted at edge E0 gives valid_out_conv2 = 1 after edge E0+G (4 cycles).
- Throughput: one window per G+1 cycles with out_ready held high. OUT accepts the next window in the same cycle the output is consumed.
- ready_out is combinational from state and out_ready. All other outputs are registered, except w_grp, which is decoded from registered grp.
- Handshake: a transfer occurs only when valid and ready are both high at a rising edge.
- Simultaneous reset and handshake: reset wins.

## Test plan
- All-zero ROM:
  - pixel_windows = 72'h0 -> popcount 72 per channel -> conv2_out = 16'hFFFF, valid 4 cycles after accept.
  - pixel_windows = all ones -> conv2_out = 16'h0000 with valid_out_conv2 = 1.
- Threshold boundary, ROM zero:
  - window with exactly 36 zero bits (72'hFF_FFFF_FFF0_0000_0000) -> all bits 1.
  - window with 35 zero bits -> all bits 0.
- Per-channel mapping:
  - ROM channel c = all ones for odd c, zero for even c; window = 0 -> conv2_out = 16'h5555.
  - w_grp sequence observed is 0,1,2,3.
- Backpressure:
  - out_ready low 5 cycles in OUT -> conv2_out and valid held, ready_out = 0, a pending valid_in_buf is not accepted.
  - Raising out_ready -> output consumed and next window accepted in the same cycle.
- Streaming: valid_in_buf high with 3 distinct windows, out_ready high -> 3 outputs in order, spaced 5 cycles apart.
- Reset asserted while grp = 2 -> valid_out_conv2 = 0 and conv2_out = 0 immediately, state IDLE. The next window after release gives a correct output with no stale bits.
